// File: rtl/signal_generator_if.sv
// Configuration handshake bundle for the square-wave generator.
// A transfer happens on an edge where cfgValid and cfgReady are both high.
interface signal_generator_if #(
  parameter int WIDTH = 32
);
  logic             cfgValid;
  logic             cfgReady;
  logic [WIDTH-1:0] cfgPeriod;
  logic [WIDTH-1:0] cfgHigh;

  modport master (
    output cfgValid,
    output cfgPeriod,
    output cfgHigh,
    input  cfgReady
  );

  modport slave (
    input  cfgValid,
    input  cfgPeriod,
    input  cfgHigh,
    output cfgReady
  );
endinterface

// File: rtl/signal_generator.sv
// Programmable square-wave generator with period-aligned reconfiguration,
// rising-edge counter and a free-running gate-time pulse.
module signal_generator #(
  parameter int WIDTH      = 32,
  parameter int GATE_DIV   = 50000000,
  parameter int DEF_PERIOD = 2,
  parameter int DEF_HIGH   = 1
) (
  input  logic                sysClk,
  input  logic                sysRstN,
  input  logic                enable,
  signal_generator_if.slave   cfg,
  output logic                signal,
  output logic                periodStart,
  output logic                realTimeTikTok,
  output logic [31:0]         edgeCount
);

  localparam int DW = (GATE_DIV > 1) ? $clog2(GATE_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(GATE_DIV - 1);
  localparam logic [WIDTH-1:0] MIN_PER = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic {
    S_READY,
    S_PEND
  } cfg_st_e;

  cfg_st_e st_q, st_d;

  logic [WIDTH-1:0] phase_q, phase_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic [WIDTH-1:0] pendPer_q, pendPer_d;
  logic [WIDTH-1:0] pendHigh_q, pendHigh_d;
  logic [DW-1:0]    div_q, div_d;
  logic [31:0]      edges_q, edges_d;
  logic             sig_q, sig_d;
  logic             ps_q, ps_d;
  logic             tik_q, tik_d;

  logic             fire;
  logic             wrap;
  logic             apply;
  logic             divLast;
  logic [WIDTH-1:0] clampPer;

  assign fire    = cfg.cfgValid && (st_q == S_READY);
  assign wrap    = enable && (phase_q == per_q - ONE);
  assign apply   = (st_q == S_PEND) && (wrap || !enable);
  assign divLast = (div_q == DIV_LAST);

  assign clampPer = (cfg.cfgPeriod < MIN_PER) ? MIN_PER
                                              : cfg.cfgPeriod;

  always_ff @(posedge sysClk or negedge sysRstN) begin
    if (!sysRstN) begin
      st_q <= S_READY;
    end else begin
      st_q <= st_d;
    end
  end

  // New values only take effect on a period boundary, so the
  // period in progress always finishes with the old settings.
  always_comb begin
    st_d       = st_q;
    per_d      = per_q;
    high_d     = high_q;
    pendPer_d  = pendPer_q;
    pendHigh_d = pendHigh_q;
    unique case (st_q)
      S_READY: begin
        if (fire) begin
          st_d       = S_PEND;
          pendPer_d  = clampPer;
          pendHigh_d = cfg.cfgHigh;
        end
      end
      S_PEND: begin
        if (apply) begin
          st_d   = S_READY;
          per_d  = pendPer_q;
          high_d = pendHigh_q;
        end
      end
    endcase
  end

  always_comb begin
    phase_d = '0;
    if (enable && !wrap) begin
      phase_d = phase_q + ONE;
    end
    sig_d   = enable && (phase_q < high_q);
    ps_d    = enable && (phase_q == '0);
    edges_d = edges_q + {31'd0, sig_d & ~sig_q};
    div_d   = divLast ? '0 : div_q + DW'(1);
    tik_d   = divLast;
  end

  always_ff @(posedge sysClk or negedge sysRstN) begin
    if (!sysRstN) begin
      phase_q    <= '0;
      per_q      <= WIDTH'(DEF_PERIOD);
      high_q     <= WIDTH'(DEF_HIGH);
      pendPer_q  <= '0;
      pendHigh_q <= '0;
      div_q      <= '0;
      edges_q    <= '0;
      sig_q      <= 1'b0;
      ps_q       <= 1'b0;
      tik_q      <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      per_q      <= per_d;
      high_q     <= high_d;
      pendPer_q  <= pendPer_d;
      pendHigh_q <= pendHigh_d;
      div_q      <= div_d;
      edges_q    <= edges_d;
      sig_q      <= sig_d;
      ps_q       <= ps_d;
      tik_q      <= tik_d;
    end
  end

  assign cfg.cfgReady   = (st_q == S_READY);
  assign signal         = sig_q;
  assign periodStart    = ps_q;
  assign realTimeTikTok = tik_q;
  assign edgeCount      = edges_q;

endmodule

// File: tb/tb_signal_generator.sv
// Randomized and directed bench for signal_generator against a
// period/phase reference model.
module tb_signal_generator;

  localparam int GD = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        sig;
  logic        ps;
  logic        tik;
  logic [31:0] edges;

  signal_generator_if #(.WIDTH(32)) cif ();

  signal_generator #(
    .WIDTH(32),
    .GATE_DIV(GD),
    .DEF_PERIOD(2),
    .DEF_HIGH(1)
  ) dut (
    .sysClk(clk),
    .sysRstN(rst_n),
    .enable(en),
    .cfg(cif.slave),
    .signal(sig),
    .periodStart(ps),
    .realTimeTikTok(tik),
    .edgeCount(edges)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference state in spec terms: where we are in the period,
  // the active shape, and at most one waiting configuration.
  bit          m_ready;
  bit          m_pend;
  int          m_pp, m_ph;
  int          m_per, m_hi;
  int          m_phase;
  int          m_cyc;
  bit          m_sig, m_ps, m_tik;
  logic [31:0] m_edges;

  task automatic model_reset();
    m_ready = 1; m_pend = 0;
    m_pp = 0; m_ph = 0;
    m_per = 2; m_hi = 1;
    m_phase = 0; m_cyc = 0;
    m_sig = 0; m_ps = 0; m_tik = 0;
    m_edges = 0;
  endtask

  task automatic model_step(input bit e, input bit v,
                            input int p, input int h);
    bit fire, apply, nsig;
    fire  = v && m_ready;
    apply = m_pend && (!e || m_phase == m_per - 1);
    nsig  = e && (m_phase < m_hi);
    if (nsig && !m_sig) m_edges = m_edges + 1;
    m_sig   = nsig;
    m_ps    = e && (m_phase == 0);
    m_phase = e ? (m_phase + 1) % m_per : 0;
    if (apply) begin
      m_per = m_pp; m_hi = m_ph;
      m_pend = 0; m_ready = 1;
    end
    if (fire) begin
      m_pp = (p < 2) ? 2 : p; m_ph = h;
      m_pend = 1; m_ready = 0;
    end
    m_cyc++;
    m_tik = (m_cyc % GD) == 0;
  endtask

  task automatic compare_all(input string ctx);
    check({ctx, ".sig"}, 32'(sig), 32'(m_sig));
    check({ctx, ".ps"}, 32'(ps), 32'(m_ps));
    check({ctx, ".tik"}, 32'(tik), 32'(m_tik));
    check({ctx, ".edges"}, edges, m_edges);
    check({ctx, ".rdy"}, 32'(cif.cfgReady), 32'(m_ready));
  endtask

  task automatic tick(input string ctx, input bit e, input bit v,
                      input int p, input int h);
    en = e;
    cif.cfgValid  = v;
    cif.cfgPeriod = 32'(p);
    cif.cfgHigh   = 32'(h);
    @(posedge clk);
    model_step(e, v, p, h);
    @(negedge clk);
    compare_all(ctx);
  endtask

  logic [31:0] base;

  initial begin
    cif.cfgValid = 1'b0;
    cif.cfgPeriod = '0;
    cif.cfgHigh = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("rst");
    rst_n = 1'b1;

    // defaults 2/1
    for (int i = 0; i < 8; i++) begin
      tick("def", 1, 0, 0, 0);
      check("def.pat", 32'(sig), 32'(i % 2 == 0));
    end

    // 4/1 loaded while idle
    tick("idle", 0, 0, 0, 0);
    tick("c41", 0, 1, 4, 1);
    check("c41.rdy_lo", 32'(cif.cfgReady), 32'd0);
    tick("c41b", 0, 0, 0, 0);
    check("c41.rdy_hi", 32'(cif.cfgReady), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick("r41", 1, 0, 0, 0);
      check("r41.pat", 32'(sig), 32'(i % 4 == 0));
    end

    // 5/2 offered mid-period, held valid once while not ready
    tick("m1", 1, 0, 0, 0);
    tick("m2", 1, 1, 5, 2);
    tick("m3", 1, 1, 7, 3);
    for (int i = 0; i < 12; i++) tick("r52", 1, 0, 0, 0);

    // clamp and constant levels
    tick("c00", 1, 1, 0, 0);
    for (int i = 0; i < 8; i++) tick("r00", 1, 0, 0, 0);
    check("r00.low", 32'(sig), 32'd0);
    base = edges;
    tick("c37", 1, 1, 3, 7);
    for (int i = 0; i < 10; i++) tick("r37", 1, 0, 0, 0);
    check("r37.high", 32'(sig), 32'd1);
    check("r37.once", edges, base + 32'd1);

    // enable toggling must not disturb the gate pulse
    for (int i = 0; i < 30; i++)
      tick("tog", bit'(i % 3 != 0), 0, 0, 0);

    // reset with a configuration still waiting
    tick("p41", 0, 1, 4, 1);
    tick("p41b", 0, 0, 0, 0);
    tick("p1", 1, 0, 0, 0);
    tick("p2", 1, 1, 6, 3);
    #2 rst_n = 1'b0;
    #1;
    check("ar.sig", 32'(sig), 32'd0);
    check("ar.ps", 32'(ps), 32'd0);
    check("ar.tik", 32'(tik), 32'd0);
    check("ar.edges", edges, 32'd0);
    check("ar.rdy", 32'(cif.cfgReady), 32'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick("post", 1, 0, 0, 0);
      check("post.pat", 32'(sig), 32'(i % 2 == 0));
    end

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      tick("rnd",
           bit'($urandom % 8 != 0),
           bit'($urandom % 4 == 0),
           int'($urandom % 8),
           int'($urandom % 9));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/signal_generator.md
SIGNAL_GENERATOR -- requirements
Module: signal_generator

Interface
REQ-001 SHALL have parameter WIDTH, default 32: bit width of the period, high-time and phase counters.
REQ-002 SHALL have parameter GATE_DIV, default 50000000: realTimeTikTok interval in sysClk cycles, valid range 2 or more.
REQ-003 SHALL have parameter DEF_PERIOD, default 2: active period after reset.
REQ-004 SHALL have parameter DEF_HIGH, default 1: active high-time after reset.
REQ-005 SHALL have port sysClk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port sysRstN, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port enable, input, 1 bit: waveform run enable.
REQ-008 SHALL have port cfgValid, input, 1 bit: new configuration offered.
REQ-009 SHALL have port cfgReady, output, 1 bit: configuration can be accepted.
REQ-010 SHALL have port cfgPeriod, input, WIDTH bits: requested period in sysClk cycles.
REQ-011 SHALL have port cfgHigh, input, WIDTH bits: requested high-time in sysClk cycles.
REQ-012 SHALL have port signal, output, 1 bit: generated square wave, registered.
REQ-013 SHALL have port periodStart, output, 1 bit: one-cycle pulse aligned with the first cycle of each period.
REQ-014 SHALL have port realTimeTikTok, output, 1 bit: one-cycle gate pulse every GATE_DIV cycles.
REQ-015 SHALL have port edgeCount, output, 32 bits: count of signal rising edges.

Function
REQ-016 SHALL hold phaseCnt in the range 0 to activePeriod-1; phaseCnt increments each cycle while enable=1 and wraps to 0 after activePeriod-1.
REQ-017 SHALL, while enable=0, hold phaseCnt=0, drive signal=0 on the next cycle, and drive periodStart=0.
REQ-018 SHALL register signal as (phaseCnt < activeHigh) and periodStart as (enable && phaseCnt==0), both sampled at the same edge; latency from enable rising to the first signal=1 is one cycle.
REQ-019 SHALL keep signal constant 1 when activeHigh >= activePeriod and constant 0 when activeHigh=0; periodStart still pulses every period in both cases.
REQ-020 SHALL clamp cfgPeriod values 0 and 1 to 2 on capture; cfgHigh is captured unmodified.
REQ-021 SHALL use a handshake in which a transfer occurs on an edge with cfgValid && cfgReady; cfgPeriod and cfgHigh are then captured into pending registers and cfgReady goes 0 on the next cycle.
REQ-022 SHALL load pending values into activePeriod and activeHigh at the edge where phaseCnt wraps (phaseCnt == activePeriod-1 with enable=1), or at the next edge if enable=0; the period in progress completes with the old values.
REQ-023 SHALL reassert cfgReady in the cycle after pending values are applied; cfgValid while cfgReady=0 is ignored, with no queueing.
REQ-024 SHALL restart phaseCnt at 0 when enable is deasserted mid-period, and any pending configuration is applied on the next edge.
REQ-025 SHALL count, in edgeCount, each cycle where signal goes 0 to 1; edgeCount wraps from 0xFFFFFFFF to 0 and is unaffected by enable.
REQ-026 SHALL run the realTimeTikTok divider freely, independent of enable and configuration; the first pulse occurs GATE_DIV cycles after reset release, then one pulse every GATE_DIV cycles.

Reset
REQ-027 SHALL, while sysRstN=0, asynchronously force signal=0, periodStart=0, realTimeTikTok=0, edgeCount=0, cfgReady=1, phaseCnt=0, activePeriod=DEF_PERIOD, activeHigh=DEF_HIGH, no pending configuration, and divider count=0.
REQ-028 SHALL discard any pending configuration when reset is asserted mid-operation; outputs take their reset values immediately, and normal operation resumes on the first edge after sysRstN rises.

Verification
REQ-029 SHALL verify: after reset, enable=1 with defaults -> signal 1,0,1,0...; periodStart pulses every 2 cycles; edgeCount increments every 2 cycles.
REQ-030 SHALL verify: cfgPeriod=4, cfgHigh=1 with enable=0, then enable=1 -> signal 1,0,0,0 repeating from one cycle after enable; cfgReady low for exactly one cycle after the transfer.
REQ-031 SHALL verify: config 5/2 sent at mid-period of an active 4/1 waveform -> the current 4-cycle period finishes, then 5/2 waveform starts; cfgValid held while cfgReady=0 is not captured.
REQ-032 SHALL verify: cfgPeriod=0, cfgHigh=0 -> period clamped to 2, signal constant 0, periodStart every 2 cycles; then cfgPeriod=3, cfgHigh=7 -> signal constant 1, edgeCount incremented once.
REQ-033 SHALL verify: GATE_DIV=10 -> realTimeTikTok pulses at cycles 10, 20, 30 after reset release regardless of enable toggling.
REQ-034 SHALL verify: sysRstN pulsed low mid-period with a pending configuration -> all outputs are reset asynchronously, active values return to 2/1, and the pending configuration is never applied.
